// File: rtl/sample_widen_loader.sv
// Frame loader: widens S(IN) I/Q samples to the FFT word format and buffers one frame; SAMPLE_WIDEN_LOADER_BIT_REVERSE_EN selects bit-reversed drain order.
// Latency: the first output is valid one cycle after the last input of a frame is accepted; each phase moves one sample per cycle.
// Backpressure: in_ready is low for the whole drain phase; while out_valid && !out_ready the outputs hold.
module sample_widen_loader #(
    parameter int IN_WORD_LENGTH   = 8,
    parameter int IN_INT_LENGTH    = 0,
    parameter int IN_FLOAT_LENGTH  = 7,
    parameter int OUT_WORD_LENGTH  = 9,
    parameter int OUT_INT_LENGTH   = 0,
    parameter int OUT_FLOAT_LENGTH = 8,
    parameter int N_POINTS         = 16,
    parameter int ADDR_WIDTH       = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [IN_WORD_LENGTH-1:0]  i_in,
    input  logic [IN_WORD_LENGTH-1:0]  q_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OUT_WORD_LENGTH-1:0] i_out,
    output logic [OUT_WORD_LENGTH-1:0] q_out,
    output logic [ADDR_WIDTH-1:0]      out_index,
    output logic                       out_first,
    output logic                       out_last
);

    localparam int SHIFT = OUT_FLOAT_LENGTH - IN_FLOAT_LENGTH;
    localparam int EXT   = OUT_INT_LENGTH - IN_INT_LENGTH;
    localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(N_POINTS - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_M1 = ADDR_WIDTH'(N_POINTS - 2);

    typedef enum logic {FILL, DRAIN} state_t;

    // Sign-extend into the extra integer bits, then pad the extra fraction bits with zeros.
    function automatic logic [OUT_WORD_LENGTH-1:0] widen(input logic [IN_WORD_LENGTH-1:0] x);
        logic signed [IN_WORD_LENGTH+EXT-1:0] ext_v;
        logic [OUT_WORD_LENGTH-1:0]           w;
        ext_v = (IN_WORD_LENGTH + EXT)'($signed(x));
        w     = OUT_WORD_LENGTH'(ext_v);
        return w << SHIFT;
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] order(input logic [ADDR_WIDTH-1:0] k);
        logic [ADDR_WIDTH-1:0] r;
`ifdef SAMPLE_WIDEN_LOADER_BIT_REVERSE_EN
        for (int b = 0; b < ADDR_WIDTH; b++) begin
            r[b] = k[ADDR_WIDTH-1-b];
        end
`else
        r = k;
`endif
        return r;
    endfunction

    state_t                     state, state_nxt;
    logic [ADDR_WIDTH-1:0]      wr_cnt, wr_nxt;
    logic [ADDR_WIDTH-1:0]      rd_cnt, rd_nxt;
    logic                       in_ready_nxt, out_valid_nxt, first_nxt, last_nxt;
    logic                       wr_en, load;
    logic [ADDR_WIDTH-1:0]      load_k;
    logic [OUT_WORD_LENGTH-1:0] mem_i [N_POINTS];
    logic [OUT_WORD_LENGTH-1:0] mem_q [N_POINTS];

    always_comb begin
        state_nxt     = state;
        wr_nxt        = wr_cnt;
        rd_nxt        = rd_cnt;
        in_ready_nxt  = in_ready;
        out_valid_nxt = out_valid;
        first_nxt     = out_first;
        last_nxt      = out_last;
        wr_en         = 1'b0;
        load          = 1'b0;
        load_k        = '0;
        case (state)
            FILL: begin
                in_ready_nxt = 1'b1;
                if (in_valid && in_ready) begin
                    wr_en  = 1'b1;
                    wr_nxt = wr_cnt + 1'b1;
                    if (wr_cnt == LAST) begin
                        state_nxt     = DRAIN;
                        in_ready_nxt  = 1'b0;
                        out_valid_nxt = 1'b1;
                        first_nxt     = 1'b1;
                        last_nxt      = (LAST == '0);
                        load          = 1'b1;
                    end
                end
            end
            DRAIN: begin
                in_ready_nxt = 1'b0;
                if (out_valid && out_ready) begin
                    if (rd_cnt == LAST) begin
                        state_nxt     = FILL;
                        rd_nxt        = '0;
                        out_valid_nxt = 1'b0;
                        first_nxt     = 1'b0;
                        last_nxt      = 1'b0;
                        in_ready_nxt  = 1'b1;
                    end else begin
                        rd_nxt    = rd_cnt + 1'b1;
                        load      = 1'b1;
                        load_k    = rd_cnt + 1'b1;
                        first_nxt = 1'b0;
                        last_nxt  = (rd_cnt == LAST_M1);
                    end
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
            i_out     <= '0;
            q_out     <= '0;
            out_index <= '0;
        end else begin
            state     <= state_nxt;
            wr_cnt    <= wr_nxt;
            rd_cnt    <= rd_nxt;
            in_ready  <= in_ready_nxt;
            out_valid <= out_valid_nxt;
            out_first <= first_nxt;
            out_last  <= last_nxt;
            if (load) begin
                i_out     <= mem_i[order(load_k)];
                q_out     <= mem_q[order(load_k)];
                out_index <= order(load_k);
            end
        end
    end

    // Buffer is never cleared: a fresh frame always overwrites every slot before draining.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_i[wr_cnt] <= widen(i_in);
            mem_q[wr_cnt] <= widen(q_in);
        end
    end

endmodule

// File: tb/tb_sample_widen_loader.sv
// Randomised bench for sample_widen_loader with a frame-level reference model and a per-cycle compare process.
module tb_sample_widen_loader;
    localparam int IW = 8;
    localparam int OW = 9;
    localparam int IFL = 7;
    localparam int OFL = 8;
    localparam int N  = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [IW-1:0] i_in = '0;
    logic [IW-1:0] q_in = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [OW-1:0] i_out, q_out;
    logic [AW-1:0] out_index;
    logic          out_first, out_last;

    int n_cmp = 0;
    int n_err = 0;

    sample_widen_loader dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .i_in(i_in), .q_in(q_in), .out_valid(out_valid), .out_ready(out_ready),
        .i_out(i_out), .q_out(q_out), .out_index(out_index),
        .out_first(out_first), .out_last(out_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Lossless widening as a value: same real number, finer fractional grid.
    function automatic logic [OW-1:0] widen_m(input logic [IW-1:0] x);
        int v;
        v = $signed(x);
        v = v * (1 << (OFL - IFL));
        return OW'(v);
    endfunction

    function automatic int ord_m(input int k);
`ifdef SAMPLE_WIDEN_LOADER_BIT_REVERSE_EN
        int r = 0;
        for (int b = 0; b < AW; b++) if (k[b]) r = r | (1 << (AW - 1 - b));
        return r;
`else
        return k;
`endif
    endfunction

    // Model: expected observable values for the current cycle.
    logic          e_rdy, e_vld, e_first, e_last;
    logic [OW-1:0] e_i, e_q;
    logic [AW-1:0] e_idx;
    logic [OW-1:0] fq_i[$], fq_q[$];
    logic [OW-1:0] fr_i[N], fr_q[N];
    int            k_out;

    // Log of DUT handshakes for the literal checks.
    logic [OW-1:0] lg_i[$], lg_q[$];
    logic [AW-1:0] lg_idx[$];
    logic          lg_f[$], lg_l[$];
    int            n_out = 0;

    task automatic present(input int k);
        int idx;
        idx     = ord_m(k);
        e_idx   = AW'(idx);
        e_i     = fr_i[idx];
        e_q     = fr_q[idx];
        e_first = (k == 0);
        e_last  = (k == N - 1);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_in_ready", in_ready, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_i_out", i_out, 0);
            chk("rst_q_out", q_out, 0);
            chk("rst_out_index", out_index, 0);
            chk("rst_first_last", {out_first, out_last}, 0);
            e_rdy = 0; e_vld = 0; e_first = 0; e_last = 0;
            e_i = '0; e_q = '0; e_idx = '0; k_out = 0;
            fq_i.delete(); fq_q.delete();
        end else begin
            chk("in_ready", in_ready, e_rdy);
            chk("out_valid", out_valid, e_vld);
            chk("i_out", i_out, e_i);
            chk("q_out", q_out, e_q);
            chk("out_index", out_index, e_idx);
            chk("out_first", out_first, e_first);
            chk("out_last", out_last, e_last);
            if (out_valid && out_ready) begin
                lg_i.push_back(i_out); lg_q.push_back(q_out); lg_idx.push_back(out_index);
                lg_f.push_back(out_first); lg_l.push_back(out_last);
                n_out++;
            end
            if (in_valid && e_rdy) begin
                fq_i.push_back(widen_m(i_in));
                fq_q.push_back(widen_m(q_in));
                if (fq_i.size() == N) begin
                    for (int j = 0; j < N; j++) begin
                        fr_i[j] = fq_i[j];
                        fr_q[j] = fq_q[j];
                    end
                    fq_i.delete(); fq_q.delete();
                    e_rdy = 0; e_vld = 1; k_out = 0;
                    present(0);
                end
            end else if (e_vld && out_ready) begin
                k_out++;
                if (k_out == N) begin
                    e_vld = 0; e_first = 0; e_last = 0; e_rdy = 1;
                end else begin
                    present(k_out);
                end
            end else if (!e_vld) begin
                e_rdy = 1;
            end
        end
    end

    logic [IW-1:0] src_i[N], src_q[N];
    logic          pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    task automatic clear_log();
        lg_i.delete(); lg_q.delete(); lg_idx.delete(); lg_f.delete(); lg_l.delete();
    endtask

    task automatic rand_src();
        for (int j = 0; j < N; j++) begin
            src_i[j] = IW'($urandom);
            src_q[j] = IW'($urandom);
        end
    endtask

    // vmode 0: in_valid always 1; 1: random. rmode 0: ready 1; 1: 1,0,0,1 pattern; 2: random.
    // After the frame is accepted in_valid stays 1 with junk data until the drain completes.
    task automatic run_frame(input int vmode, input int rmode);
        int p = 0;
        int cyc = 0;
        int outs0 = n_out;
        while ((n_out - outs0) < N && cyc < 400) begin
            in_valid  = (p < N) ? ((vmode == 0) ? 1'b1 : 1'($urandom_range(0, 1))) : 1'b1;
            i_in      = (p < N) ? src_i[p] : IW'($urandom);
            q_in      = (p < N) ? src_q[p] : IW'($urandom);
            out_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? pat[cyc % 4] : 1'($urandom_range(0, 1));
            @(negedge clk); #1;
            if (in_valid && in_ready && p < N) p++;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        chk("frame_output_count", n_out - outs0, N);
    endtask

    initial begin
        logic [OW-1:0] by_i[N], by_q[N];
        int seq[N];
        int nf, nl;

        // Reset with in_valid high.
        in_valid = 1'b1; i_in = 8'h55; q_in = 8'h33;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Frame A: widening values.
        rand_src();
        src_i[0] = 8'h40; src_i[1] = 8'h80; src_i[2] = 8'hFF; src_q[3] = 8'h7F;
        clear_log();
        run_frame(0, 0);
        for (int j = 0; j < lg_i.size(); j++) begin
            by_i[lg_idx[j]] = lg_i[j];
            by_q[lg_idx[j]] = lg_q[j];
        end
        chk("widen_40", by_i[0], 9'h080);
        chk("widen_80", by_i[1], 9'h100);
        chk("widen_FF", by_i[2], 9'h1FE);
        chk("widen_7F", by_q[3], 9'h0FE);

        // Frame B: ramp input, drain order.
`ifdef SAMPLE_WIDEN_LOADER_BIT_REVERSE_EN
        seq = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
`else
        seq = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
`endif
        for (int j = 0; j < N; j++) begin
            src_i[j] = IW'(j);
            src_q[j] = IW'($urandom);
        end
        clear_log();
        run_frame(0, 0);
        nf = 0; nl = 0;
        for (int j = 0; j < N && j < lg_i.size(); j++) begin
            chk("seq_index", lg_idx[j], seq[j]);
            chk("seq_i_out", lg_i[j], 2 * seq[j]);
            nf += int'(lg_f[j]);
            nl += int'(lg_l[j]);
        end
        chk("first_count", nf, 1);
        chk("last_count", nl, 1);
        if (lg_f.size() == N) begin
            chk("first_on_0", lg_f[0], 1);
            chk("last_on_15", lg_l[N-1], 1);
        end

        // Frame C: stalled drain.
        rand_src();
        run_frame(0, 1);

        // Reset after 7 accepted samples, then a clean frame.
        begin
            int p = 0;
            rand_src();
            while (p < 7) begin
                in_valid = 1'b1; i_in = src_i[p]; q_in = src_q[p]; out_ready = 1'b1;
                @(negedge clk); #1;
                if (in_ready) p++;
                @(posedge clk); #1;
            end
            rst_n = 1'b0;
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b1;
        end
        rand_src();
        clear_log();
        run_frame(0, 0);
        chk("post_reset_outputs", lg_i.size(), N);
        for (int j = 0; j < lg_i.size(); j++) begin
            chk("post_reset_data", lg_i[j], widen_m(src_i[ord_m(j)]));
        end

        // Random frames.
        repeat (5) begin
            rand_src();
            run_frame(1, 2);
        end
        repeat (3) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
